// File: rtl/crc32_fifo_sched_if.sv
// rtl/crc32_fifo_sched_if.sv - FWFT byte FIFO read port seen by the CRC-32 sequencer
interface crc32_fifo_sched_if;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_done;

  // master: the sequencer popping bytes; slave: the FIFO presenting them
  modport master (input fifo_dout, input fifo_empty, output fifo_done);
  modport slave (output fifo_dout, output fifo_empty, input fifo_done);
endinterface

// File: rtl/crc32_fifo_sched.sv
// rtl/crc32_fifo_sched.sv - pops FIFO bytes and folds them LSB-first into a bit-serial CRC-32
module crc32_fifo_sched #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       finish,
  crc32_fifo_sched_if.master         fifo,
  output logic                       busy,
  output logic                       crc_valid,
  output logic [31:0]                crc_out,
  output logic [15:0]                byte_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINAL} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] crc;
  logic [31:0] crc_step;
  logic [7:0]  sh;
  logic [2:0]  bitcnt;
  logic        armed;
  logic        fin_pend;
  logic        fb;

  always_comb begin
    fb       = crc[0] ^ sh[0];
    crc_step = (crc >> 1) ^ (fb ? POLY : 32'h0000_0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Data waiting in the FIFO always beats a pending finish, so late bytes join the message
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (armed && !fifo.fifo_empty) begin
            state_nxt = LOAD;
          end else if (armed && fin_pend) begin
            state_nxt = FINAL;
          end
        end
        LOAD:  state_nxt = SHIFT;
        SHIFT: begin
          if (bitcnt == 3'd7) begin
            state_nxt = IDLE;
          end
        end
        FINAL: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed            <= 1'b0;
      fin_pend         <= 1'b0;
      crc              <= INIT;
      sh               <= 8'h00;
      bitcnt           <= 3'd0;
      fifo.fifo_done   <= 1'b0;
      busy             <= 1'b0;
      crc_valid        <= 1'b0;
      crc_out          <= 32'h0000_0000;
      byte_count       <= 16'h0000;
    end else begin
      // Registered decodes of the state being entered, so they line up with LOAD/SHIFT
      fifo.fifo_done <= (state_nxt == LOAD);
      busy           <= (state_nxt == LOAD) || (state_nxt == SHIFT);

      if (start) begin
        crc        <= INIT;
        byte_count <= 16'h0000;
        crc_valid  <= 1'b0;
        armed      <= 1'b1;
        fin_pend   <= 1'b0;
      end else begin
        if (finish && armed) begin
          fin_pend <= 1'b1;
        end
        case (state)
          LOAD: begin
            sh     <= fifo.fifo_dout;
            bitcnt <= 3'd0;
          end
          SHIFT: begin
            crc    <= crc_step;
            sh     <= sh >> 1;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              byte_count <= byte_count + 16'd1;
            end
          end
          FINAL: begin
            crc_out   <= crc ^ XOROUT;
            crc_valid <= 1'b1;
            armed     <= 1'b0;
            fin_pend  <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
